// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD-card target that decodes 6-byte commands and streams host response bytes.
// Latency: cmd_valid 1 clk after the CRC byte's 8th synchronised SCLK rise; MISO follows SCLK by ~3 clk (2-FF sync + edge detect).
// Backpressure: cmd_valid held until cmd_ready; resp bytes taken only at byte boundaries, fill bytes sent while host idle.
//
// Ports:
//   clk_clk, reset_reset_n            system clock, async active-low reset
//   spi_sclk/spi_cs/spi_mosi/spi_miso SPI mode 0 target pins (inputs 2-FF synchronised, SCLK <= clk_clk/8)
//   cmd_valid/cmd_ready               decoded command handshake; cmd_index/cmd_arg/cmd_crc carry the frame
//   resp_valid/resp_ready             host response byte offer; resp_ready pulses one clk when resp_data is taken
//   resp_data/resp_last               response byte and final-byte marker
//   resp_timeout                      one-clk pulse when NCR_MAX fill bytes pass without a response
//   busy                              FSM is not idle
//
// Optional feature: define SD_CRC7_CHECK_EN to verify CRC7 over bytes 0..4; a mismatching frame is not
// presented and the card answers with a single R1 byte 8'h08 instead.

module sd_spi_responder #(
  parameter int         NCR_MAX   = 8,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [7:0]  resp_data,
  input  logic        resp_last,
  output logic        resp_timeout,
  output logic        busy
);

  localparam logic [7:0] NCR_LIM = 8'(NCR_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_PRESENT,
    S_WAIT,
    S_SEND
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers. SCLK gets a third stage so edges can be detected on
  // the synchronised copy; MOSI shares the SCLK delay so it is sampled aligned.
  // ---------------------------------------------------------------------------
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q;
  logic mosi_s1_q, mosi_s2_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= spi_sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= spi_cs;
      cs_s2_q   <= cs_s1_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic cs_act;
  logic sclk_rise;
  logic sclk_fall;

  assign cs_act    = ~cs_s2_q;
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        load_pend_q, load_pend_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic [6:0]  cmd_crc_q, cmd_crc_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  ncr_q, ncr_d;
  logic        last_q, last_d;
  logic        resp_ready_q, resp_ready_d;
  logic        resp_timeout_q, resp_timeout_d;

`ifdef SD_CRC7_CHECK_EN
  localparam logic [7:0] R1_CRC_ERR = 8'h08;

  logic [6:0] crc_calc_q, crc_calc_d;
  logic       err_pend_q, err_pend_d;

  // CRC7, poly x^7+x^3+1, MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      crc_calc_q <= 7'd0;
      err_pend_q <= 1'b0;
    end else begin
      crc_calc_q <= crc_calc_d;
      err_pend_q <= err_pend_d;
    end
  end
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= 3'd0;
      rx_shift_q     <= 7'd0;
      tx_shift_q     <= FILL_BYTE;
      load_pend_q    <= 1'b0;
      byte_idx_q     <= 3'd0;
      cmd_index_q    <= 6'd0;
      cmd_arg_q      <= 32'd0;
      cmd_crc_q      <= 7'd0;
      cmd_valid_q    <= 1'b0;
      ncr_q          <= 8'd0;
      last_q         <= 1'b0;
      resp_ready_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      load_pend_q    <= load_pend_d;
      byte_idx_q     <= byte_idx_d;
      cmd_index_q    <= cmd_index_d;
      cmd_arg_q      <= cmd_arg_d;
      cmd_crc_q      <= cmd_crc_d;
      cmd_valid_q    <= cmd_valid_d;
      ncr_q          <= ncr_d;
      last_q         <= last_d;
      resp_ready_q   <= resp_ready_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       load_pt;

  always_comb begin
    rx_byte        = {rx_shift_q, mosi_s2_q};
    byte_done      = cs_act & sclk_rise & (bit_cnt_q == 3'd7);
    load_pt        = cs_act & sclk_fall & load_pend_q;

    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    load_pend_d    = load_pend_q;
    byte_idx_d     = byte_idx_q;
    cmd_index_d    = cmd_index_q;
    cmd_arg_d      = cmd_arg_q;
    cmd_crc_d      = cmd_crc_q;
    cmd_valid_d    = cmd_valid_q;
    ncr_d          = ncr_q;
    last_d         = last_q;
    resp_ready_d   = 1'b0;
    resp_timeout_d = 1'b0;
`ifdef SD_CRC7_CHECK_EN
    crc_calc_d     = crc_calc_q;
    err_pend_d     = err_pend_q;
`endif

    if (!cs_act) begin
      // Deselect aborts whatever is in flight and re-aligns the bit counter.
      bit_cnt_d   = 3'd0;
      tx_shift_d  = FILL_BYTE;
      load_pend_d = 1'b0;
      state_d     = S_IDLE;
      cmd_valid_d = 1'b0;
      last_d      = 1'b0;
`ifdef SD_CRC7_CHECK_EN
      err_pend_d  = 1'b0;
`endif
    end else begin
      if (sclk_rise) begin
        rx_shift_d = rx_byte[6:0];
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) load_pend_d = 1'b1;
      end

      // The falling edge after a completed byte loads a fresh TX byte so its
      // MSB is on MISO before the master's next rising edge. The FSM below
      // may override the fill byte with response data.
      if (sclk_fall) begin
        if (load_pend_q) begin
          load_pend_d = 1'b0;
          tx_shift_d  = FILL_BYTE;
        end else begin
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end
      end

      case (state_q)
        S_IDLE: begin
          if (byte_done && (rx_byte[7:6] == 2'b01)) begin
            cmd_index_d = rx_byte[5:0];
            byte_idx_d  = 3'd0;
            state_d     = S_COLLECT;
`ifdef SD_CRC7_CHECK_EN
            crc_calc_d  = crc7_byte(7'd0, rx_byte);
`endif
          end
        end

        S_COLLECT: begin
          if (byte_done) begin
            byte_idx_d = byte_idx_q + 3'd1;
            case (byte_idx_q)
              3'd0: cmd_arg_d[31:24] = rx_byte;
              3'd1: cmd_arg_d[23:16] = rx_byte;
              3'd2: cmd_arg_d[15:8]  = rx_byte;
              3'd3: cmd_arg_d[7:0]   = rx_byte;
              default: begin
                cmd_crc_d = rx_byte[7:1];
`ifdef SD_CRC7_CHECK_EN
                if (crc_calc_q != rx_byte[7:1]) begin
                  state_d    = S_SEND;
                  err_pend_d = 1'b1;
                end else begin
                  state_d     = S_PRESENT;
                  cmd_valid_d = 1'b1;
                end
`else
                state_d     = S_PRESENT;
                cmd_valid_d = 1'b1;
`endif
              end
            endcase
`ifdef SD_CRC7_CHECK_EN
            if (byte_idx_q < 3'd4) crc_calc_d = crc7_byte(crc_calc_q, rx_byte);
`endif
          end
        end

        S_PRESENT: begin
          // A load point in this state always sends fill; the response search
          // starts at the next load point after the handshake.
          if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
            ncr_d       = 8'd0;
            state_d     = S_WAIT;
          end
        end

        S_WAIT: begin
          if (load_pt) begin
            if (resp_valid) begin
              tx_shift_d   = resp_data;
              resp_ready_d = 1'b1;
              last_d       = resp_last;
              state_d      = S_SEND;
            end else begin
              ncr_d = ncr_q + 8'd1;
              if ((ncr_q + 8'd1) == NCR_LIM) begin
                resp_timeout_d = 1'b1;
                state_d        = S_IDLE;
              end
            end
          end
        end

        S_SEND: begin
          if (load_pt) begin
            if (last_q) begin
              // Final byte has just been shifted out completely.
              last_d  = 1'b0;
              state_d = S_IDLE;
`ifdef SD_CRC7_CHECK_EN
            end else if (err_pend_q) begin
              tx_shift_d = R1_CRC_ERR;
              err_pend_d = 1'b0;
              last_d     = 1'b1;
`endif
            end else if (resp_valid) begin
              tx_shift_d   = resp_data;
              resp_ready_d = 1'b1;
              last_d       = resp_last;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign spi_miso     = tx_shift_q[7];
  assign cmd_valid    = cmd_valid_q;
  assign cmd_index    = cmd_index_q;
  assign cmd_arg      = cmd_arg_q;
  assign cmd_crc      = cmd_crc_q;
  assign resp_ready   = resp_ready_q;
  assign resp_timeout = resp_timeout_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: directed bench for sd_spi_responder acting as an SPI master plus host.
// Latency: each SPI bit is 10 system clocks; host actions are placed between bytes.
// Backpressure: host offers one response byte per SPI byte and withdraws it after resp_ready.

module tb_sd_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b1;
  logic        spi_miso;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [7:0]  resp_data = 8'h00;
  logic        resp_last = 1'b0;
  logic        resp_timeout;
  logic        busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int rr_cnt = 0;
  int to_cnt = 0;

  logic [7:0] resp_mem [0:515];

  sd_spi_responder #(.NCR_MAX(8), .FILL_BYTE(8'hFF)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .spi_sclk     (spi_sclk),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_crc      (cmd_crc),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_last    (resp_last),
    .resp_timeout (resp_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-cycle outputs.
  always @(posedge clk) begin
    if (resp_ready)   rr_cnt++;
    if (resp_timeout) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (5) @(negedge clk);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (5) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Leading FF (ignored by the card), then the six frame bytes.
  task automatic send_frame(input logic [47:0] f);
    logic [7:0] rx;
    spi_xfer(8'hFF, rx);
    for (int b = 0; b < 6; b++) spi_xfer(f[47-8*b -: 8], rx);
    clks(6);
  endtask

  task automatic wait_cmd(output logic got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake;
    @(negedge clk) cmd_ready = 1'b1;
    @(negedge clk) cmd_ready = 1'b0;
    clks(2);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [7:0]  exp_b;
    logic        got;
    int          rr0;
    int          to0;
    logic [39:0] body;

    // ---------------- reset values ----------------
    clks(4);
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    clks(3);
    spi_cs = 1'b0;
    clks(4);

    // ---------------- reset mid-frame ----------------
    spi_xfer(8'h51, rx);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h12, rx);
    spi_xfer(8'h34, rx);
    clks(6);
    check("mid_frame_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst2_miso", 32'(spi_miso), 32'd1);
    check("rst2_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst2_index", 32'(cmd_index), 32'd0);
    check("rst2_arg", cmd_arg, 32'd0);
    check("rst2_crc", 32'(cmd_crc), 32'd0);
    check("rst2_resp_ready", 32'(resp_ready), 32'd0);
    check("rst2_timeout", 32'(resp_timeout), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    clks(4);

    // ---------------- CMD0 with R1 = 01 ----------------
    send_frame({8'h40, 32'h0000_0000, 8'h95});
    wait_cmd(got);
    check("cmd0_valid", 32'(got), 32'd1);
    check("cmd0_index", 32'(cmd_index), 32'd0);
    check("cmd0_arg", cmd_arg, 32'd0);
    check("cmd0_crc", 32'(cmd_crc), 32'h4A);
    handshake();
    check("cmd0_valid_drop", 32'(cmd_valid), 32'd0);
    check("cmd0_busy", 32'(busy), 32'd1);
    rr0 = rr_cnt;
    resp_valid = 1'b1; resp_data = 8'h01; resp_last = 1'b1;
    spi_xfer(8'hFF, rx);
    clks(6);
    resp_valid = 1'b0; resp_last = 1'b0;
    check("cmd0_ncr_ff", 32'(rx), 32'hFF);
    check("cmd0_rr_pulse", 32'(rr_cnt - rr0), 32'd1);
    spi_xfer(8'hFF, rx);
    clks(6);
    check("cmd0_r1", 32'(rx), 32'h01);
    check("cmd0_busy_after", 32'(busy), 32'd0);
    spi_xfer(8'hFF, rx);
    clks(6);
    check("cmd0_trail_ff", 32'(rx), 32'hFF);

    // ---------------- CMD17 read block stream ----------------
    body = {8'h51, 32'h0000_1234};
    send_frame({body, crc7(body), 1'b1});
    wait_cmd(got);
    check("cmd17_valid", 32'(got), 32'd1);
    check("cmd17_index", 32'(cmd_index), 32'd17);
    check("cmd17_arg", cmd_arg, 32'h0000_1234);
    handshake();
    resp_mem[0] = 8'h00;
    resp_mem[1] = 8'hFE;
    for (int i = 0; i < 512; i++) resp_mem[2+i] = i[7:0] ^ 8'hA5;
    resp_mem[514] = 8'h3C;
    resp_mem[515] = 8'hC3;
    rr0 = rr_cnt;
    for (int k = 0; k <= 517; k++) begin
      if (k < 516) begin
        resp_valid = 1'b1; resp_data = resp_mem[k]; resp_last = (k == 515);
      end
      spi_xfer(8'hFF, rx);
      clks(6);
      resp_valid = 1'b0; resp_last = 1'b0;
      exp_b = (k == 0 || k == 517) ? 8'hFF : resp_mem[k-1];
      check($sformatf("cmd17_byte%0d", k), 32'(rx), 32'(exp_b));
    end
    check("cmd17_rr_count", 32'(rr_cnt - rr0), 32'd516);
    check("cmd17_busy_after", 32'(busy), 32'd0);

    // ---------------- CMD8 with no host response: timeout ----------------
    body = {8'h48, 32'h0000_01AA};
    send_frame({body, crc7(body), 1'b1});
    wait_cmd(got);
    check("cmd8_valid", 32'(got), 32'd1);
    check("cmd8_arg", cmd_arg, 32'h0000_01AA);
    handshake();
    to0 = to_cnt;
    for (int k = 0; k < 8; k++) begin
      spi_xfer(8'hFF, rx);
      clks(6);
      check($sformatf("ncr_ff%0d", k), 32'(rx), 32'hFF);
      if (k == 6) begin
        check("ncr7_no_timeout", 32'(to_cnt - to0), 32'd0);
        check("ncr7_busy", 32'(busy), 32'd1);
      end
    end
    check("ncr_timeout_once", 32'(to_cnt - to0), 32'd1);
    check("ncr_busy_after", 32'(busy), 32'd0);

    // ---------------- CS abort mid-frame ----------------
    spi_xfer(8'h51, rx);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h00, rx);
    clks(6);
    check("abort_busy_before", 32'(busy), 32'd1);
    spi_cs = 1'b1;
    clks(6);
    check("abort_cmd_valid", 32'(cmd_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    spi_cs = 1'b0;
    clks(4);
    send_frame({8'h40, 32'h0000_0000, 8'h95});
    wait_cmd(got);
    check("abort_next_valid", 32'(got), 32'd1);
    check("abort_next_index", 32'(cmd_index), 32'd0);
    check("abort_next_arg", cmd_arg, 32'd0);
    spi_cs = 1'b1;
    clks(6);
    check("abort_present_valid", 32'(cmd_valid), 32'd0);
    check("abort_present_busy", 32'(busy), 32'd0);
    spi_cs = 1'b0;
    clks(4);

    // ---------------- CMD0 with bad CRC byte 0x97 ----------------
    send_frame({8'h40, 32'h0000_0000, 8'h97});
    wait_cmd(got);
`ifdef SD_CRC7_CHECK_EN
    check("badcrc_no_valid", 32'(got), 32'd0);
    check("badcrc_busy", 32'(busy), 32'd1);
    spi_xfer(8'hFF, rx);
    clks(6);
    check("badcrc_r1", 32'(rx), 32'h08);
    check("badcrc_busy_after", 32'(busy), 32'd0);
    spi_xfer(8'hFF, rx);
    clks(6);
    check("badcrc_trail_ff", 32'(rx), 32'hFF);
`else
    check("badcrc_presented", 32'(got), 32'd1);
    check("badcrc_crc_field", 32'(cmd_crc), 32'h4B);
    spi_cs = 1'b1;
    clks(6);
    check("badcrc_abort_busy", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
